// File: rtl/gpio_input_poller.sv
// gpio_input_poller: periodically reads GPIO_1.DATA_IN, debounces
// it and latches edges into pending flags behind a masked interrupt.
module gpio_input_poller #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int POLL_DIV = 1000,
  parameter int DEB_CNT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [ADDR_W-1:0] m_raddr,
  output logic              m_ren,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [15:0]       irq_mask,
  input  logic [15:0]       clr_pend,
  output logic [15:0]       gpio_state,
  output logic [15:0]       rise_pend,
  output logic [15:0]       fall_pend,
  output logic              sample_stb,
  output logic              irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CAPTURE
  } state_e;

  localparam logic [15:0] RELOAD  = 16'(POLL_DIV - 1);
  localparam logic [3:0]  DEB_MAX = 4'(DEB_CNT);

  state_e      state_q;
  state_e      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] cand_q;
  logic [15:0] cand_d;
  logic [3:0]  stab_q;
  logic [3:0]  stab_d;
  logic [15:0] gpio_q;
  logic [15:0] gpio_d;
  logic [15:0] rise_q;
  logic [15:0] rise_d;
  logic [15:0] fall_q;
  logic [15:0] fall_d;
  logic        irq_q;
  logic        irq_d;

  logic [15:0] smp;
  logic        commit;
  logic [15:0] rise_set;
  logic [15:0] fall_set;

  // Only DATA_IN is consumed; the rest of the read word is ignored.
  logic unused_rdata;
  assign unused_rdata = ^m_rdata;
  assign smp = m_rdata[31:16];

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      stab_q  <= '0;
      gpio_q  <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      gpio_q  <= gpio_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      irq_q   <= irq_d;
    end
  end

  // Next-state: READ/CAPTURE always finish; WAIT aborts on !enable.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (cnt_q == 16'd0) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = enable ? S_WAIT : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus strobe and sample pulse decoded from the current state.
  always_comb begin
    m_raddr    = '0;
    m_ren      = 1'b0;
    sample_stb = 1'b0;
    unique case (1'b1)
      (state_q == S_READ): begin
        m_ren = 1'b1;
      end
      (state_q == S_CAPTURE): begin
        sample_stb = 1'b1;
      end
      default: begin
        m_ren = 1'b0;
      end
    endcase
  end

  // Poll interval counter: loaded on entry to WAIT, counts to zero.
  always_comb begin
    cnt_d = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          cnt_d = RELOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_CAPTURE: begin
        if (enable) begin
          cnt_d = RELOAD;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Debounce: a value commits after DEB_CNT identical samples.
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    commit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cand_d = '0;
        stab_d = '0;
      end
      S_CAPTURE: begin
        if (smp != cand_q) begin
          cand_d = smp;
          stab_d = 4'd1;
        end else if (stab_q != DEB_MAX) begin
          stab_d = stab_q + 4'd1;
        end
        commit = (stab_d == DEB_MAX) &&
                 (cand_d != gpio_q);
      end
      default: begin
        cand_d = cand_q;
      end
    endcase
  end

  // Committed value, sticky edge flags (set beats clear) and irq.
  always_comb begin
    gpio_d   = gpio_q;
    rise_set = '0;
    fall_set = '0;
    if (commit) begin
      gpio_d   = cand_d;
      rise_set = cand_d & ~gpio_q;
      fall_set = ~cand_d & gpio_q;
    end
    rise_d = (rise_q & ~clr_pend) | rise_set;
    fall_d = (fall_q & ~clr_pend) | fall_set;
    irq_d  = |((rise_q | fall_q) & irq_mask);
  end

  assign gpio_state = gpio_q;
  assign rise_pend  = rise_q;
  assign fall_pend  = fall_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_input_poller.sv
// tb_gpio_input_poller: directed table, corner sequences and a
// random run against a sample-history reference model.
module tb_gpio_input_poller;

  localparam int NI  = 2;
  localparam int PD0 = 4;
  localparam int DB0 = 3;
  localparam int PD1 = 1;
  localparam int DB1 = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] din;
  logic [15:0] irq_mask;
  logic [15:0] clr_pend;

  logic [31:0] m_raddr0, m_raddr1;
  logic        m_ren0, m_ren1;
  logic [31:0] m_rdata0 = '0;
  logic [31:0] m_rdata1 = '0;
  logic [15:0] gpio_state0, gpio_state1;
  logic [15:0] rise_pend0, rise_pend1;
  logic [15:0] fall_pend0, fall_pend1;
  logic        sample_stb0, sample_stb1;
  logic        irq0, irq1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  gpio_input_poller #(
    .ADDR_W(32), .DATA_W(32),
    .POLL_DIV(PD0), .DEB_CNT(DB0)
  ) u0 (
    .clk(clk), .rst(rst), .enable(enable),
    .m_raddr(m_raddr0), .m_ren(m_ren0),
    .m_rdata(m_rdata0), .irq_mask(irq_mask),
    .clr_pend(clr_pend), .gpio_state(gpio_state0),
    .rise_pend(rise_pend0), .fall_pend(fall_pend0),
    .sample_stb(sample_stb0), .irq(irq0)
  );

  gpio_input_poller #(
    .ADDR_W(32), .DATA_W(32),
    .POLL_DIV(PD1), .DEB_CNT(DB1)
  ) u1 (
    .clk(clk), .rst(rst), .enable(enable),
    .m_raddr(m_raddr1), .m_ren(m_ren1),
    .m_rdata(m_rdata1), .irq_mask(irq_mask),
    .clr_pend(clr_pend), .gpio_state(gpio_state1),
    .rise_pend(rise_pend1), .fall_pend(fall_pend1),
    .sample_stb(sample_stb1), .irq(irq1)
  );

  // CSR slaves: registered read data, one cycle after the strobe.
  always @(posedge clk) begin
    if (m_ren0) m_rdata0 <= {din, 16'($urandom)};
    if (m_ren1) m_rdata1 <= {din, 16'($urandom)};
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: absolute read times and a window of samples.
  int          cyc = 0;
  int          rd_at[NI];
  int          cap_at[NI];
  int          hcnt[NI];
  logic [15:0] hist[NI][16];
  logic [15:0] smp[NI];
  logic [15:0] e_st[NI];
  logic [15:0] e_r[NI];
  logic [15:0] e_f[NI];
  logic        e_irq[NI];
  int          pdv, dbv;
  logic [15:0] nr, nf;
  bit          same;

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      pdv = (k == 0) ? PD0 : PD1;
      dbv = (k == 0) ? DB0 : DB1;
      if (rst) begin
        rd_at[k]  = -1;
        cap_at[k] = -1;
        hcnt[k]   = 0;
        smp[k]    = '0;
        e_st[k]   = '0;
        e_r[k]    = '0;
        e_f[k]    = '0;
        e_irq[k]  = 1'b0;
      end else begin
        e_irq[k] = |((e_r[k] | e_f[k]) & irq_mask);
        nr = '0;
        nf = '0;
        if (cap_at[k] == cyc) begin
          for (int j = 15; j > 0; j--) hist[k][j] = hist[k][j-1];
          hist[k][0] = smp[k];
          if (hcnt[k] < 16) hcnt[k]++;
          same = 1'b1;
          for (int j = 0; j < dbv; j++)
            if (hist[k][j] != smp[k]) same = 1'b0;
          if (hcnt[k] >= dbv && same && smp[k] != e_st[k]) begin
            nr = smp[k] & ~e_st[k];
            nf = ~smp[k] & e_st[k];
            e_st[k] = smp[k];
          end
          if (enable) rd_at[k] = cyc + pdv + 1;
          else begin
            rd_at[k] = -1;
            hcnt[k]  = 0;
          end
        end else if (rd_at[k] == cyc) begin
          cap_at[k] = cyc + 1;
          smp[k]    = din;
        end else if (rd_at[k] > cyc) begin
          if (!enable) begin
            rd_at[k] = -1;
            hcnt[k]  = 0;
          end
        end else begin
          hcnt[k] = 0;
          if (enable) rd_at[k] = cyc + pdv + 1;
        end
        e_r[k] = (e_r[k] & ~clr_pend) | nr;
        e_f[k] = (e_f[k] & ~clr_pend) | nf;
      end
    end
    cyc++;
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("u0.m_ren", 32'(m_ren0), 32'(cyc == rd_at[0]));
      chk("u0.stb", 32'(sample_stb0), 32'(cyc == cap_at[0]));
      chk("u0.raddr", m_raddr0, 32'd0);
      chk("u0.state", 32'(gpio_state0), 32'(e_st[0]));
      chk("u0.rise", 32'(rise_pend0), 32'(e_r[0]));
      chk("u0.fall", 32'(fall_pend0), 32'(e_f[0]));
      chk("u0.irq", 32'(irq0), 32'(e_irq[0]));
      chk("u1.m_ren", 32'(m_ren1), 32'(cyc == rd_at[1]));
      chk("u1.stb", 32'(sample_stb1), 32'(cyc == cap_at[1]));
      chk("u1.raddr", m_raddr1, 32'd0);
      chk("u1.state", 32'(gpio_state1), 32'(e_st[1]));
      chk("u1.rise", 32'(rise_pend1), 32'(e_r[1]));
      chk("u1.fall", 32'(fall_pend1), 32'(e_f[1]));
      chk("u1.irq", 32'(irq1), 32'(e_irq[1]));
    end
  end

  int rens[$];
  always @(negedge clk) begin
    if (m_ren0) rens.push_back(cyc);
  end

  typedef struct {
    logic [15:0] din;
    logic [15:0] clr;
    logic [15:0] st;
    logic [15:0] r;
    logic [15:0] f;
    logic        irq;
  } vec_t;

  vec_t tbl[10];

  task automatic wait_stb();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_stb0 && n < 200);
    chk("stb_timeout", 32'(sample_stb0), 32'd1);
  endtask

  task automatic wait_ren();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_ren0 && n < 200);
    chk("ren_timeout", 32'(m_ren0), 32'd1);
  endtask

  task automatic poll(input vec_t v, input string nm);
    din = v.din;
    wait_stb();
    clr_pend = v.clr;
    @(negedge clk);
    clr_pend = '0;
    chk({nm, ".state"}, 32'(gpio_state0), 32'(v.st));
    chk({nm, ".rise"}, 32'(rise_pend0), 32'(v.r));
    chk({nm, ".fall"}, 32'(fall_pend0), 32'(v.f));
    @(negedge clk);
    chk({nm, ".irq"}, 32'(irq0), 32'(v.irq));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  int t0;
  int nren;

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    din      = '0;
    irq_mask = '0;
    clr_pend = '0;

    tbl[0] = '{16'h5, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0};
    tbl[1] = '{16'h5, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0};
    tbl[2] = '{16'h5, 16'h0, 16'h5, 16'h5, 16'h0, 1'b1};
    tbl[3] = '{16'h4, 16'h0, 16'h5, 16'h5, 16'h0, 1'b1};
    tbl[4] = '{16'h4, 16'h0, 16'h5, 16'h5, 16'h0, 1'b1};
    tbl[5] = '{16'h4, 16'h0, 16'h4, 16'h5, 16'h1, 1'b1};
    tbl[6] = '{16'h4, 16'h1, 16'h4, 16'h4, 16'h0, 1'b0};
    tbl[7] = '{16'h6, 16'h0, 16'h4, 16'h4, 16'h0, 1'b0};
    tbl[8] = '{16'h6, 16'h0, 16'h4, 16'h4, 16'h0, 1'b0};
    tbl[9] = '{16'h6, 16'h2, 16'h6, 16'h6, 16'h0, 1'b0};

    // Reset and idle: no reads while disabled.
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    nren   = 0;
    repeat (100) begin
      @(negedge clk);
      if (m_ren0) nren++;
    end
    chk("idle.nren", 32'(nren), 32'd0);
    chk("idle.state", 32'(gpio_state0), 32'd0);
    chk("idle.irq", 32'(irq0), 32'd0);

    // Commit, fall, clear and set/clear collision rows.
    irq_mask = 16'h0001;
    din      = 16'h0005;
    rens.delete();
    t0     = cyc;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      poll(tbl[i], $sformatf("row%0d", i));
      if (i == 2) begin
        chk("ren.count", 32'(rens.size() >= 3), 32'd1);
        if (rens.size() >= 3) begin
          chk("ren.first", 32'(rens[0]), 32'(t0 + PD0 + 1));
          chk("ren.second", 32'(rens[1]), 32'(t0 + 2 * PD0 + 3));
          chk("ren.third", 32'(rens[2]), 32'(t0 + 3 * PD0 + 5));
        end
      end
    end

    // Disable during WAIT: no more reads, value retained.
    wait_stb();
    repeat (2) @(negedge clk);
    enable = 1'b0;
    nren   = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_ren0) nren++;
    end
    chk("dis_wait.nren", 32'(nren), 32'd0);
    chk("dis_wait.state", 32'(gpio_state0), 32'h6);

    // Disable during READ: CAPTURE still happens, then idle.
    enable = 1'b1;
    wait_ren();
    enable = 1'b0;
    @(negedge clk);
    chk("dis_read.stb", 32'(sample_stb0), 32'd1);
    nren = 0;
    repeat (30) begin
      @(negedge clk);
      if (m_ren0) nren++;
    end
    chk("dis_read.nren", 32'(nren), 32'd0);

    // Reset during CAPTURE clears everything next cycle.
    irq_mask = 16'hffff;
    enable   = 1'b1;
    wait_stb();
    chk("pre_rst.irq", 32'(irq0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
    chk("rst_cap.state", 32'(gpio_state0), 32'd0);
    chk("rst_cap.rise", 32'(rise_pend0), 32'd0);
    chk("rst_cap.irq", 32'(irq0), 32'd0);
    chk("rst_cap.stb", 32'(sample_stb0), 32'd0);
    chk("rst_cap.ren", 32'(m_ren0), 32'd0);

    // Bounce rejection: alternating samples never commit.
    do_reset();
    irq_mask = 16'h0001;
    enable   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      wait_stb();
    end
    repeat (2) @(negedge clk);
    chk("bounce.state", 32'(gpio_state0), 32'd0);
    chk("bounce.rise", 32'(rise_pend0), 32'd0);
    chk("bounce.fall", 32'(fall_pend0), 32'd0);
    chk("bounce.irq", 32'(irq0), 32'd0);

    // Random run against the model.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 0) din = 16'($urandom);
        else din = din ^ (16'h1 << $urandom_range(0, 15));
      end
      clr_pend = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
      if ($urandom_range(0, 49) == 0) irq_mask = 16'($urandom);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      rst = ($urandom_range(0, 999) == 0);
    end
    @(negedge clk);
    rst      = 1'b0;
    clr_pend = '0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
